muldiv: RTL and testbench



---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 83 ++++++++
 rtl/muldiv.sv | 144 ++++++++++++++
 tb/tb_muldiv.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// muldiv_pkg : shared operation select codes and FSM state encodings for muldiv
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
//------------------------------------------------------------------------------
// muldiv_iter : unsigned shift-add multiply / restoring divide, one bit per step
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_iter #(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              div_i,
   input  logic              word_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic [XLEN-1:0]   sr_o
);

   logic              div_q,  div_d;
   logic [2*XLEN-1:0] acc_q,  acc_d;
   logic [2*XLEN-1:0] mag_q,  mag_d;
   logic [XLEN-1:0]   sr_q,   sr_d;
   logic [XLEN:0]     w_rsh;
   logic [XLEN:0]     w_rsub;
   logic              w_ge;

   assign w_rsh  = {acc_q[XLEN-1:0], sr_q[XLEN-1]};
   assign w_rsub = w_rsh - {1'b0, mag_q[XLEN-1:0]};
   assign w_ge   = (w_rsh >= {1'b0, mag_q[XLEN-1:0]});

   always_comb begin
      div_d = div_q;
      acc_d = acc_q;
      mag_d = mag_q;
      sr_d  = sr_q;
      if (load_i) begin
         div_d = div_i;
         acc_d = '0;
         if (div_i) begin
            // Word dividends are parked at the top so the MSB shifts out first.
            mag_d = {{XLEN{1'b0}}, b_i};
            sr_d  = word_i ? (a_i << (XLEN/2)) : a_i;
         end else begin
            mag_d = {{XLEN{1'b0}}, a_i};
            sr_d  = b_i;
         end
      end else if (step_i) begin
         if (div_q) begin
            acc_d = {{(XLEN-1){1'b0}}, (w_ge ? w_rsub : w_rsh)};
            sr_d  = {sr_q[XLEN-2:0], w_ge};
         end else begin
            if (sr_q[0]) begin
               acc_d = acc_q + mag_q;
            end
            mag_d = mag_q << 1;
            sr_d  = sr_q >> 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= 1'b0;
         acc_q <= '0;
         mag_q <= '0;
         sr_q  <= '0;
      end else begin
         div_q <= div_d;
         acc_q <= acc_d;
         mag_q <= mag_d;
         sr_q  <= sr_d;
      end
   end

   assign acc_o = acc_q;
   assign sr_o  = sr_q;

endmodule

`default_nettype wire

// File: rtl/muldiv.sv
//------------------------------------------------------------------------------
// muldiv   : multi-cycle RISC-V M-extension multiply/divide unit (XLEN 32/64)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      mdsel,
   input  logic            word,
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] z
);

   localparam int              CW    = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] LO32  = XLEN'(32'hFFFF_FFFF);
   localparam logic [XLEN-1:0] MIN32 = XLEN'(32'h8000_0000);

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return (v & LO32) | (v[31] ? ~LO32 : '0);
   endfunction

   state_e            state_q;
   logic [CW-1:0]     count_q;
   logic [XLEN-1:0]   z_q;
   logic [2:0]        op_q;
   logic              word_q;
   logic              negp_q, negq_q, negr_q;

   logic              w_word, w_signx, w_signy, w_sx, w_sy;
   logic [XLEN-1:0]   w_wmask, w_minw, w_xe, w_ye, w_ax, w_ay;
   logic              w_divz, w_ovf, w_special, w_accept;
   logic [XLEN-1:0]   w_sp_raw;
   logic [2*XLEN-1:0] w_acc, w_prod;
   logic [XLEN-1:0]   w_sr, w_mulres, w_q, w_r, w_res;

   assign w_word   = word && (XLEN == 64);
   assign w_wmask  = w_word ? LO32 : {XLEN{1'b1}};
   assign w_minw   = w_word ? MIN32 : {1'b1, {(XLEN-1){1'b0}}};
   assign w_xe     = x & w_wmask;
   assign w_ye     = y & w_wmask;
   assign w_sx     = w_word ? x[31] : x[XLEN-1];
   assign w_sy     = w_word ? y[31] : y[XLEN-1];
   assign w_signx  = mdsel inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   assign w_signy  = mdsel inside {MD_MULH, MD_DIV, MD_REM};
   assign w_ax     = (w_signx && w_sx) ? ((-w_xe) & w_wmask) : w_xe;
   assign w_ay     = (w_signy && w_sy) ? ((-w_ye) & w_wmask) : w_ye;

   // Divide-by-zero and signed overflow bypass the iteration entirely.
   assign w_divz    = mdsel[2] && (w_ye == '0);
   assign w_ovf     = mdsel[2] && !mdsel[0] && (w_xe == w_minw) && (w_ye == w_wmask);
   assign w_special = w_divz || w_ovf;
   assign w_sp_raw  = w_divz ? (mdsel[1] ? w_xe : {XLEN{1'b1}})
                             : (mdsel[1] ? '0   : w_xe);
   assign w_accept  = in_valid && (state_q == ST_IDLE) && !flush;

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (w_accept && !w_special),
      .step_i (state_q == ST_CALC),
      .div_i  (mdsel[2]),
      .word_i (w_word),
      .a_i    (w_ax),
      .b_i    (w_ay),
      .acc_o  (w_acc),
      .sr_o   (w_sr)
   );

   assign w_prod   = negp_q ? -w_acc : w_acc;
   assign w_mulres = (op_q == MD_MUL) ? w_prod[XLEN-1:0]
                   : (word_q ? XLEN'(w_prod[63:32]) : w_prod[2*XLEN-1:XLEN]);
   assign w_q      = negq_q ? -w_sr : w_sr;
   assign w_r      = negr_q ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
   assign w_res    = op_q[2] ? (op_q[1] ? w_r : w_q) : w_mulres;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         z_q     <= '0;
         op_q    <= '0;
         word_q  <= 1'b0;
         negp_q  <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else if (flush) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q   <= mdsel;
                  word_q <= w_word;
                  negp_q <= (mdsel == MD_MULH) ? (w_sx ^ w_sy) : ((mdsel == MD_MULHSU) && w_sx);
                  negq_q <= mdsel[2] && !mdsel[0] && (w_sx ^ w_sy);
                  negr_q <= mdsel[2] && !mdsel[0] && w_sx;
                  if (w_special) begin
                     z_q     <= w_word ? sext32(w_sp_raw) : w_sp_raw;
                     state_q <= ST_DONE;
                  end else begin
                     count_q <= w_word ? CW'(32) : CW'(XLEN);
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               z_q     <= word_q ? sext32(w_res) : w_res;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign z         = z_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv.sv
//------------------------------------------------------------------------------
// tb_muldiv : table-driven, scoreboard-checked bench for muldiv (XLEN=64)
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv;
   import muldiv_pkg::*;

   localparam int XLEN = 64;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            flush     = 1'b0;
   logic            in_valid  = 1'b0;
   logic            in_ready;
   logic [2:0]      mdsel     = 3'd0;
   logic            word      = 1'b0;
   logic [XLEN-1:0] x         = '0;
   logic [XLEN-1:0] y         = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [XLEN-1:0] z;

   typedef struct {
      logic [2:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
      string       nm;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] sb[$];
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   muldiv #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mdsel     (mdsel),
      .word      (word),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] e, input int lat,
                      input string nm);
      vec_t v;
      v.op = op; v.w = w; v.a = a; v.b = b; v.exp = e; v.lat = lat; v.nm = nm;
      vecs.push_back(v);
   endtask

   // Waits for out_valid after an accept, then checks latency and pops the scoreboard.
   task automatic collect(input string nm, input int lat);
      int          n;
      logic [63:0] e;
      n = 1;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, 64'(n), 64'(lat));
      if (sb.size() == 0) begin
         chk({nm, " scoreboard empty"}, 64'(1), 64'(0));
      end else begin
         e = sb.pop_front();
         chk({nm, " z"}, z, e);
      end
   endtask

   // Called at a negedge with the unit expected idle; returns at a negedge.
   task automatic run_op(input vec_t v);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({v.nm, " in_ready before issue"}, 64'(in_ready), 64'(1));
      mdsel = v.op; word = v.w; x = v.a; y = v.b; in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(v.exp);
      @(negedge clk);
      in_valid = 1'b0;
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      mdsel = 3'($urandom); word = 1'($urandom);
      collect(v.nm, v.lat);
      @(negedge clk);
   endtask

   initial begin
      int   n;
      logic seen;
      vec_t v;

      add(MD_MUL,    0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, "MUL 7*-3");
      add(MD_MULHU,  0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, "MULHU max*max");
      add(MD_MULHSU, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "MULHSU -1*2");
      add(MD_MULH,   0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, 66, "MULH min*min");
      add(MD_MULH,   0, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 66, "MULH -3*5");
      add(MD_DIV,    0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "DIV -7/2");
      add(MD_REM,    0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "REM -7/2");
      add(MD_DIVU,   0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 66, "DIVU big/2");
      add(MD_REMU,   0, 64'd100, 64'd7, 64'd2, 66, "REMU 100/7");
      add(MD_DIV,    0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "DIV 5/0");
      add(MD_REMU,   0, 64'd5, 64'd0, 64'd5, 1, "REMU 5/0");
      add(MD_DIV,    0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "DIV ovf");
      add(MD_REM,    0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "REM ovf");
      add(MD_MUL,    1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, "MULW");
      add(MD_DIV,    1, 64'h1_0000_0014, 64'd4, 64'd5, 34, "DIVW");
      add(MD_DIVU,   1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34, "DIVUW");
      add(MD_REM,    1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, "REMW -7/2");
      add(MD_DIV,    1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, "DIVW by 0");
      add(MD_REMU,   1, 64'h8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1, "REMUW by 0");
      add(MD_DIV,    1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "DIVW ovf");

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset in_ready", 64'(in_ready), 64'(1));
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset z", z, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_op(vecs[i]);

      // Backpressure: hold DONE with out_ready low while in_valid pokes at the unit
      out_ready = 1'b0;
      mdsel = MD_MUL; word = 1'b0; x = 64'd6; y = 64'd7; in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(64'd42);
      @(negedge clk);
      in_valid = 1'b0;
      collect("backpressure", 66);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; mdsel = MD_DIV; x = 64'd100; y = 64'd0;
         @(negedge clk);
         chk("bp hold z", z, 64'd42);
         chk("bp hold in_ready", 64'(in_ready), 64'(0));
         chk("bp hold out_valid", 64'(out_valid), 64'(1));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp release out_valid", 64'(out_valid), 64'(0));
      chk("bp release in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      chk("bp no stray op", 64'(out_valid), 64'(0));

      // Flush in the middle of CALC
      mdsel = MD_MULHU; word = 1'b0; x = 64'h1234_5678_9ABC_DEF0; y = 64'hFEDC_BA98; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush in_ready", 64'(in_ready), 64'(1));
      chk("flush out_valid", 64'(out_valid), 64'(0));
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("flush result discarded", 64'(seen), 64'(0));

      // in_valid together with flush must not be accepted
      flush = 1'b1; in_valid = 1'b1; mdsel = MD_DIV; x = 64'd5; y = 64'd0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush+valid in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      chk("flush+valid out_valid", 64'(out_valid), 64'(0));

      v.op = MD_MUL; v.w = 1'b0; v.a = 64'd3; v.b = 64'd4; v.exp = 64'd12; v.lat = 66; v.nm = "MUL 3*4 after flush";
      run_op(v);

      // Asynchronous reset mid-CALC
      mdsel = MD_DIVU; word = 1'b0; x = 64'd100; y = 64'd7; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset in_ready", 64'(in_ready), 64'(1));
      chk("async reset out_valid", 64'(out_valid), 64'(0));
      chk("async reset z", z, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n = 0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("reset result discarded", 64'(n), 64'(0));

      v.op = MD_DIVU; v.w = 1'b0; v.a = 64'd100; v.b = 64'd7; v.exp = 64'd14; v.lat = 66; v.nm = "DIVU 100/7 after reset";
      run_op(v);

      chk("scoreboard drained", 64'(sb.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
